// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_resp_fifo.sv
// Small in-order response FIFO; extra-MSB pointers distinguish full from empty.
module fetch_resp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch-stage producer: sequential PC generation, req/gnt imem issue,
// in-order response parking and push into the instruction buffer.
module instruction_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned           INST_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           MAX_OUTSTANDING = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  buf_write_en,
    output logic [INST_WIDTH-1:0] buf_data,
    input  logic                  buf_is_full,
    output logic                  buf_flush,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         discard_q;
    logic                  flush_q;

    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [INST_WIDTH-1:0] fifo_head;

    logic [CW:0]           in_use;
    logic                  grant;
    logic                  resp_ok;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Words parked in the FIFO still count against the limit, which is what
    // guarantees the FIFO can never overflow.
    assign in_use   = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req = (state_q == FETCH) && !redirect_valid
                      && (in_use < (CW + 1)'(MAX_OUTSTANDING));
    assign grant    = imem_req && imem_gnt;

    // A response with nothing outstanding (e.g. straight after reset) is ignored.
    assign resp_ok   = imem_rvalid && (outstanding_q != '0);
    assign fifo_push = resp_ok && !redirect_valid && (discard_q == '0);

    assign buf_write_en = !fifo_empty && !buf_is_full && !redirect_valid;
    assign fifo_pop     = buf_write_en;
    assign buf_data     = fifo_empty ? '0 : fifo_head;

    assign imem_addr = pc_q;
    assign buf_flush = flush_q;
    assign busy      = (state_q != IDLE) || (outstanding_q != '0);

    fetch_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (INST_WIDTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data (imem_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en) state_d = FETCH;
            FETCH:   if (!fetch_en) state_d = DRAIN;
            DRAIN: begin
                if (fetch_en)
                    state_d = FETCH;
                else if ((outstanding_q == '0) && fifo_empty)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= redirect_valid;

            case ({grant, resp_ok})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase

            // Everything still in flight after this cycle is stale.
            if (redirect_valid)
                discard_q <= outstanding_q - CW'(resp_ok);
            else if (resp_ok && (discard_q != '0))
                discard_q <= discard_q - 1'b1;

            if (redirect_valid)
                pc_q <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            else if (grant)
                pc_q <= pc_q + ADDR_WIDTH'(INST_BYTES);
        end
    end

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full && !fifo_pop));

    a_no_stray_response: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with a randomized imem responder.
module tb_instruction_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        buf_write_en;
    logic [31:0] buf_data;
    logic        buf_is_full = 1'b0;
    logic        buf_flush;
    logic        busy;

    instruction_fetch_unit #(
        .INST_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .MAX_OUTSTANDING (4),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .buf_write_en   (buf_write_en),
        .buf_data       (buf_data),
        .buf_is_full    (buf_is_full),
        .buf_flush      (buf_flush),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          gnt_pct = 100;
    int          last_due = 0;
    int          grants = 0;
    int          pushes = 0;
    logic [31:0] mpc = 32'h0;
    logic [31:0] exp_q[$];
    logic [31:0] glog[$];
    resp_t       pend[$];
    bit          redir_q = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc++;

    // Memory: random grant, in-order responses no earlier than one cycle after grant.
    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
        end else begin
            imem_gnt = ($urandom_range(99) < gnt_pct);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend[0].addr ^ KEY;
                void'(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end
    end

    // Reference model: PC sequence and the words expected to reach the buffer.
    always @(negedge clk) begin
        int due;
        if (!rst_n) begin
            exp_q.delete();
            pend.delete();
            mpc      = 32'h0;
            last_due = 0;
        end else if (redirect_valid) begin
            chk("no_issue_in_redirect", {31'h0, imem_req}, 32'h0);
            exp_q.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else if (imem_req && imem_gnt) begin
            chk("imem_addr", imem_addr, mpc);
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due < last_due) due = last_due;
            last_due = due;
            pend.push_back('{addr: imem_addr, due: due});
            exp_q.push_back(mpc ^ KEY);
            glog.push_back(imem_addr);
            mpc = mpc + 32'd4;
            grants++;
        end
    end

    // Monitor: pops the scoreboard on every buffer push.
    always @(negedge clk) begin
        logic [31:0] e;
        #1;
        if (rst_n) begin
            chk("buf_flush", {31'h0, buf_flush}, {31'h0, redir_q});
            if (buf_write_en) begin
                pushes++;
                chk("push_while_full", {31'h0, buf_is_full}, 32'h0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_push: got %h expected no push (t=%0t)", buf_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("buf_data", buf_data, e);
                end
            end
        end
        redir_q = rst_n && redirect_valid;
    end

    task automatic drain_check(input string tag);
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        buf_is_full    = 1'b0;
        gnt_pct        = 100;
        step();
        for (int i = 0; i < 80 && busy; i++) begin
            chk({tag, "_no_issue"}, {31'h0, imem_req}, 32'h0);
            step();
        end
        chk({tag, "_busy_low"}, {31'h0, busy}, 32'h0);
        chk({tag, "_all_pushed"}, exp_q.size(), 32'h0);
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int i = 0; i < 60 && glog.size() < n; i++) step();
        chk({tag, "_grant_count"}, (glog.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        // Reset held with fetch_en high.
        rst_n       = 1'b0;
        fetch_en    = 1'b1;
        buf_is_full = 1'b1;
        repeat (3) step();
        @(negedge clk); #3;
        chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_buf_write_en", {31'h0, buf_write_en}, 32'h0);
        chk("rst_buf_data", buf_data, 32'h0);
        chk("rst_buf_flush", {31'h0, buf_flush}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        step();
        rst_n  = 1'b1;
        grants = 0;
        glog.delete();
        @(negedge clk); #3;
        chk("idle_after_release", {31'h0, imem_req}, 32'h0);
        step();
        @(negedge clk); #3;
        chk("first_req", {31'h0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        // Backpressure: buffer full, only MAX_OUTSTANDING fetches may be issued.
        repeat (11) step();
        @(negedge clk); #3;
        chk("bp_grants", grants, 32'd4);
        chk("bp_req_stalled", {31'h0, imem_req}, 32'h0);
        chk("bp_no_push", {31'h0, buf_write_en}, 32'h0);
        step();
        buf_is_full = 1'b0;
        wait_grants(5, "bp_resume");
        if (glog.size() >= 5) chk("bp_resume_addr", glog[4], 32'h10);

        // Steady streaming: one push per cycle.
        repeat (10) step();
        p0 = pushes;
        repeat (20) step();
        chk("steady_push_rate", pushes - p0, 32'd20);

        // Redirect with several responses in flight.
        lat_min = 3;
        lat_max = 3;
        repeat (10) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1002;
        glog.delete();
        step();
        redirect_valid = 1'b0;
        @(negedge clk); #3;
        chk("redirect_flush_pulse", {31'h0, buf_flush}, 32'h1);
        lat_min = 1;
        lat_max = 1;
        wait_grants(1, "redirect");
        if (glog.size() >= 1) chk("redirect_addr", glog[0], 32'h0000_1000);
        repeat (20) step();

        // Drain with responses outstanding.
        lat_min = 2;
        lat_max = 2;
        drain_check("drain");

        // PC wrap, redirect taken while idle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        glog.delete();
        fetch_en = 1'b1;
        wait_grants(2, "wrap");
        if (glog.size() >= 2) begin
            chk("wrap_addr0", glog[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", glog[1], 32'h0000_0000);
        end

        // Reset in the middle of traffic.
        lat_max = 4;
        repeat (6) step();
        rst_n = 1'b0;
        step();
        @(negedge clk); #3;
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_req", {31'h0, imem_req}, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        step();
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) gnt_pct = int'($urandom_range(100, 30));
            fetch_en       = ($urandom_range(9) != 0);
            buf_is_full    = ($urandom_range(2) == 0);
            redirect_valid = ($urandom_range(29) == 0);
            redirect_pc    = $urandom;
            step();
        end
        drain_check("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
